// File: rtl/key_repeat_gen.sv
// Set-key conditioner: 2-FF synchroniser, SMPL-tick debouncer and press/hold/auto-repeat FSM producing one-CLK INC pulses.
// Optional KEY_ACCEL_EN: halves the repeat period after ACCEL_AFTER repeat pulses.
module key_repeat_gen #(
    parameter int unsigned DB_CNT      = 4,
    parameter int unsigned FIRST_DLY   = 50,
    parameter int unsigned RPT_PERIOD  = 10,
    parameter int unsigned ACCEL_AFTER = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic SMPL,
    input  logic KEY_IN,
    input  logic RPT_EN,
    output logic INC,
    output logic PRESSED,
    output logic LONG
);
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_e;

    localparam logic [8:0] DB_LIM    = 9'(DB_CNT);
    localparam logic [8:0] FIRST_LIM = 9'(FIRST_DLY);
    localparam logic [8:0] RPT_LIM   = 9'(RPT_PERIOD);

    logic       k_meta_q, k_s_q;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       pressed_q, pressed_d;
    state_e     state_q, state_d;
    logic [7:0] rpt_cnt_q, rpt_cnt_d;
    logic       inc_q, inc_d;
    logic       long_q, long_d;
    logic       rpt_pulse;
    logic       tick;
    logic [8:0] db_next, rpt_next, period;

    // Debounced level toggles after DB_CNT consecutive disagreeing samples.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        pressed_d = pressed_q;
        db_next   = {1'b0, db_cnt_q} + 9'd1;
        if (SMPL) begin
            if (k_s_q != pressed_q) begin
                if (db_next >= DB_LIM) begin
                    pressed_d = ~pressed_q;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_next[7:0];
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

`ifdef KEY_ACCEL_EN
    localparam logic [4:0] ACCEL_LIM = (ACCEL_AFTER > 15) ? 5'd16 : 5'(ACCEL_AFTER);
    localparam logic [8:0] RPT_FAST  = (RPT_PERIOD / 2 == 0) ? 9'd1 : 9'(RPT_PERIOD / 2);

    logic [3:0] accel_q, accel_d;

    always_comb begin
        accel_d = accel_q;
        if (!pressed_d) begin
            accel_d = '0;
        end else if (rpt_pulse && accel_q != 4'hF) begin
            accel_d = accel_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            accel_q <= '0;
        end else begin
            accel_q <= accel_d;
        end
    end

    assign period = ({1'b0, accel_q} >= ACCEL_LIM) ? RPT_FAST : RPT_LIM;
`else
    assign period = RPT_LIM;
`endif

    // A SMPL arriving while INC is still high is skipped so pulses never abut.
    assign tick = SMPL && !inc_q;

    // Release is judged on pressed_d so it beats a same-tick repeat threshold.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        inc_d     = 1'b0;
        rpt_pulse = 1'b0;
        rpt_next  = {1'b0, rpt_cnt_q} + 9'd1;
        case (state_q)
            ST_IDLE: begin
                rpt_cnt_d = '0;
                if (pressed_q && pressed_d) begin
                    state_d = ST_HOLD;
                    inc_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (RPT_EN && rpt_next >= FIRST_LIM) begin
                        state_d   = ST_REPEAT;
                        rpt_cnt_d = '0;
                        inc_d     = 1'b1;
                        rpt_pulse = 1'b1;
                    end else if (rpt_next >= FIRST_LIM) begin
                        rpt_cnt_d = FIRST_LIM[7:0];
                    end else begin
                        rpt_cnt_d = rpt_next[7:0];
                    end
                end
            end
            ST_REPEAT: begin
                if (!RPT_EN) begin
                    rpt_cnt_d = '0;
                end else if (tick) begin
                    if (rpt_next >= period) begin
                        rpt_cnt_d = '0;
                        inc_d     = 1'b1;
                        rpt_pulse = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_next[7:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!pressed_d) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
            inc_d     = 1'b0;
            rpt_pulse = 1'b0;
        end
        long_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            k_meta_q  <= 1'b0;
            k_s_q     <= 1'b0;
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
            inc_q     <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            k_meta_q  <= KEY_IN;
            k_s_q     <= k_meta_q;
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            inc_q     <= inc_d;
            long_q    <= long_d;
        end
    end

    assign INC     = inc_q;
    assign PRESSED = pressed_q;
    assign LONG    = long_q;

endmodule

// File: tb/tb_key_repeat_gen.sv
// Directed bench for key_repeat_gen (default build): SMPL every 10 CLK, INC timing recorded
// in SMPL ticks relative to the rising edge of PRESSED and compared to hand-computed lists.
module tb_key_repeat_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic smpl = 1'b0;
    logic key_in = 1'b0;
    logic rpt_en = 1'b1;
    logic inc, pressed, long_o;

    int tests = 0;
    int fails = 0;

    int smpl_idx = 0;
    int cyc_n = 0;
    int rise_idx = 0;
    int rise_cyc = 0;
    int first_inc_cyc = -1;
    int long_rise_rel = -1;
    int fall_rel = -1;
    int consec = 0;
    int k_idx = 0;
    bit press_seen = 1'b0;
    bit long_seen = 1'b0;
    bit prev_inc = 1'b0;
    bit prev_pressed = 1'b0;
    bit prev_long = 1'b0;
    int obs_q[$];
    logic [7:0] exp_q[$];

    key_repeat_gen dut (
        .CLK(clk),
        .RST(rst),
        .SMPL(smpl),
        .KEY_IN(key_in),
        .RPT_EN(rpt_en),
        .INC(inc),
        .PRESSED(pressed),
        .LONG(long_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One CLK: drive SMPL at negedge, then observe outputs just after posedge.
    task automatic cyc(input logic s);
        @(negedge clk);
        smpl = s;
        @(posedge clk);
        cyc_n++;
        if (s) smpl_idx++;
        #1;
        if (pressed && !prev_pressed) begin
            rise_idx = smpl_idx;
            rise_cyc = cyc_n;
            press_seen = 1'b1;
        end
        if (!pressed && prev_pressed) fall_rel = smpl_idx - rise_idx;
        if (inc) begin
            if (prev_inc) consec++;
            if (obs_q.size() == 0) first_inc_cyc = cyc_n;
            obs_q.push_back(smpl_idx - rise_idx);
        end
        if (long_o) long_seen = 1'b1;
        if (long_o && !prev_long) long_rise_rel = smpl_idx - rise_idx;
        prev_inc = inc;
        prev_pressed = pressed;
        prev_long = long_o;
    endtask

    task automatic periods(input int n);
        repeat (n) begin
            repeat (9) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    task automatic clr();
        obs_q.delete();
        exp_q.delete();
        first_inc_cyc = -1;
        long_rise_rel = -1;
        fall_rel = -1;
        press_seen = 1'b0;
        long_seen = 1'b0;
    endtask

    task automatic chk_incs(input string tag);
        chk({tag, "_inc_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) chk($sformatf("%s_inc%0d_at", tag, i), obs_q[i], int'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) cyc(1'b0);
        chk("rst_inc", int'(inc), 0);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_long", int'(long_o), 0);
        rst = 1'b0;
        cyc(1'b0);

        // 1: clean press held 20 SMPL, then release
        clr();
        key_in = 1'b1;
        k_idx = smpl_idx;
        periods(24);
        chk("s1_press_latency", rise_idx - k_idx, 4);
        chk("s1_inc_lag_clk", first_inc_cyc - rise_cyc, 1);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0};
        chk_incs("s1");
        chk("s1_long_seen", int'(long_seen), 0);
        chk("s1_released", int'(pressed), 0);

        // 2: bounce (runs of 1..3 SMPL) then stable high
        clr();
        key_in = 1'b1; periods(1);
        key_in = 1'b0; periods(2);
        key_in = 1'b1; periods(3);
        key_in = 1'b0; periods(1);
        key_in = 1'b1; periods(2);
        key_in = 1'b0; periods(1);
        chk("s2_bounce_pressed", int'(press_seen), 0);
        chk("s2_bounce_incs", obs_q.size(), 0);
        key_in = 1'b1;
        k_idx = smpl_idx;
        periods(6);
        chk("s2_press_latency", rise_idx - k_idx, 4);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0};
        chk_incs("s2");

        // 3: long hold with auto-repeat
        clr();
        key_in = 1'b1;
        periods(4);
        periods(120);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120};
        chk_incs("s3");
        chk("s3_long_rise", long_rise_rel, 50);
        chk("s3_release_at", fall_rel, 124);
        chk("s3_long_after_release", int'(long_o), 0);

        // 4: repeat disabled, then enabled at +80
        clr();
        rpt_en = 1'b0;
        key_in = 1'b1;
        periods(4);
        periods(80);
        chk("s4_incs_disabled", obs_q.size(), 1);
        chk("s4_long_disabled", int'(long_seen), 0);
        rpt_en = 1'b1;
        periods(40);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0, 8'd81, 8'd91, 8'd101, 8'd111, 8'd121};
        chk_incs("s4");
        chk("s4_long_rise", long_rise_rel, 81);

        // 5: reset at +55 with key held
        clr();
        key_in = 1'b1;
        periods(4);
        periods(55);
        rst = 1'b1;
        cyc(1'b0);
        chk("s5_rst_inc", int'(inc), 0);
        chk("s5_rst_pressed", int'(pressed), 0);
        chk("s5_rst_long", int'(long_o), 0);
        rst = 1'b0;
        clr();
        k_idx = smpl_idx;
        periods(4);
        chk("s5_repress_latency", rise_idx - k_idx, 4);
        periods(55);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0, 8'd50};
        chk_incs("s5");

        // 6: release lands on the +60 repeat tick
        clr();
        key_in = 1'b1;
        periods(4);
        periods(56);
        key_in = 1'b0;
        periods(6);
        exp_q = '{8'd0, 8'd50};
        chk_incs("s6");
        chk("s6_release_at", fall_rel, 60);
        chk("s6_long_idle", int'(long_o), 0);

        chk("no_back_to_back_inc", consec, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_repeat_gen.md
Name: key_repeat_gen

Overview:
Time-set key conditioner for the clock counters. Takes one raw push-button and produces clean one-cycle INC pulses for the counter stage's increment input.
- Stages: 2-FF synchroniser, sample-tick debouncer, press/hold/auto-repeat FSM.
- Sits between the board button pin and the counter chain's INC input. One instance per set key.

Parameters:
DB_CNT, 4, consecutive SMPL ticks of stable synchronised input needed to change the debounced level (1..255)
FIRST_DLY, 50, SMPL ticks from press to first auto-repeat (1..255)
RPT_PERIOD, 10, SMPL ticks between subsequent auto-repeats (1..255)
ACCEL_AFTER, 8, repeat pulses before period halves (used only with KEY_ACCEL_EN)

Ports:
CLK  input  1  system clock, single clock domain
RST  input  1  synchronous active-high reset
SMPL  input  1  sample tick, one CLK wide (100 Hz nominal: defaults give 40 ms / 500 ms / 100 ms)
KEY_IN  input  1  raw asynchronous button, active-high
RPT_EN  input  1  auto-repeat enable level
INC  output  1  registered one-CLK increment pulse
PRESSED  output  1  registered debounced key level
LONG  output  1  registered; high while FSM in REPEAT

Behaviour:
- Reset:
  - RST sampled on posedge CLK.
  - Clears sync FFs, debounce counter, repeat counter, FSM state (IDLE), INC, PRESSED and LONG to 0 on the next edge.
  - Mid-operation reset discards any press in progress. A key still held after reset is re-debounced and treated as a new press (one INC).
- Sync: KEY_IN passes through 2 FFs; k_s is the second stage.
- Debounce (8-bit counter):
  - Counter changes only on SMPL cycles.
  - k_s != PRESSED: counter increments. When it reaches DB_CNT, PRESSED toggles and the counter clears.
  - k_s == PRESSED: counter clears.
  - Non-SMPL cycles hold everything.
- Latency: from a clean KEY_IN edge, PRESSED changes 2 CLK + DB_CNT SMPL ticks later.
- FSM states: IDLE, HOLD, REPEAT. Repeat counter is 8 bits and counts SMPL ticks.
  - IDLE: on the cycle PRESSED rises, go to HOLD, clear counter, set INC for the next cycle. INC therefore lags PRESSED by 1 CLK.
  - HOLD: each SMPL increments the counter. If RPT_EN=1 and the counter reaches FIRST_DLY, pulse INC, clear counter, go to REPEAT. If RPT_EN=0, the counter saturates at FIRST_DLY and no pulse is issued until RPT_EN returns to 1.
  - REPEAT: LONG=1. Each SMPL increments the counter. At RPT_PERIOD, pulse INC and clear counter. While RPT_EN=0 the counter holds at 0 and no pulses are issued; counting resumes when RPT_EN returns to 1.
  - Any state: PRESSED falling → IDLE, counter cleared, LONG=0, no INC.
- Simultaneous events:
  - If PRESSED is being cleared on the same SMPL that a repeat threshold is reached, release wins and no INC is issued. The FSM evaluates the next-state value of PRESSED.
  - If a press and RST coincide, RST wins.
- INC is never wider than one CLK. INC never asserts in two consecutive cycles.
- Release produces no pulse. A key press shorter than DB_CNT SMPL ticks produces no pulse.

Optional Feature:
KEY_ACCEL_EN
- Defined: in REPEAT, after ACCEL_AFTER repeat pulses since entering REPEAT, the period becomes max(RPT_PERIOD/2, 1) until release. A 4-bit accel counter saturates and is cleared on release and on RST.
- Undefined: the period stays RPT_PERIOD indefinitely. No accel counter is synthesised and ACCEL_AFTER is ignored.

Test Plan:
All scenarios use default parameters, with SMPL every 10 CLK and "+n" meaning n SMPL ticks after PRESSED rises.
1. Clean press held 20 SMPL then released, RPT_EN=1 → PRESSED rises on the 4th stable SMPL (+2 CLK sync); exactly one INC, 1 CLK after PRESSED; LONG stays 0; no INC on release.
2. KEY_IN toggled every 1–3 SMPL for 10 SMPL, then held high → PRESSED and INC stay 0 during bounce; one INC after 4 stable SMPL.
3. Hold for 120 SMPL after press, RPT_EN=1 → INC at press, +50, +60, +70, ..., +120 (9 total); LONG high from +50 until release.
4. As scenario 3 with RPT_EN=0 → exactly 1 INC, LONG=0. Then raise RPT_EN at +80 → INC at the next SMPL (counter saturated at 50), then every 10 SMPL.
5. RST pulsed at +55 with key held → INC, PRESSED and LONG are 0 the next cycle. After RST drops, PRESSED re-rises after 2 CLK + 4 SMPL with a single INC; the next repeat is at +50 from the new press.
6. Release timed so PRESSED falls on the +60 SMPL → no INC at +60, FSM in IDLE. With KEY_ACCEL_EN and a long hold, the 9th and later repeats are spaced 5 SMPL apart.
